divmod: RTL

Parametrised sequential unsigned divider: computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor. It is the successor to the remainder-only 128-bit `mod` unit in the simulation datapath. It adds four things `mod` lacks: width selection, a quotient output, divide-by-zero detection, and explicit busy/valid handshaking with reset. It uses a radix-2 restoring algorithm that resolves one quotient bit per clock.

---
 rtl/divmod_if.sv | 24 ++
 rtl/divmod.sv | 114 +++++++++++
 2 files changed

// File: rtl/divmod_if.sv
// divmod request/result bundle.
// Master drives operands; slave returns results.
interface divmod_if #(
  parameter int WIDTH = 128
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             valid;
  logic             busy;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  quot, rem, valid, busy, div_zero
  );

  modport slave (
    input  start, a, b,
    output quot, rem, valid, busy, div_zero
  );
endinterface

// File: rtl/divmod.sv
// Radix-2 restoring unsigned divider.
// One quotient bit per clock; divide-by-zero resolves in one cycle.
module divmod #(
  parameter int WIDTH = 128
) (
  input  logic     clk,
  input  logic     rst,
  divmod_if.slave  io
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;

  // Remainder stays below b, so its low WIDTH bits are exact.
  always_comb begin
    t    = {r_q, q_q[WIDTH-1]};
    ge   = (t >= {1'b0, b_q});
    r_nx = ge ? (t[WIDTH-1:0] - b_q) : t[WIDTH-1:0];
    q_nx = {q_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    dz_d    = dz_q;
    unique case (state_q)
      RUN: begin
        q_d   = q_nx;
        r_d   = r_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = q_nx;
          rem_d   = r_nx;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        if (io.start) begin
          b_d     = io.b;
          valid_d = 1'b0;
          dz_d    = 1'b0;
          if (io.b == '0) begin
            quot_d  = '1;
            rem_d   = io.a;
            valid_d = 1'b1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = io.a;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      dz_q    <= dz_d;
    end
  end

  assign io.quot     = quot_q;
  assign io.rem      = rem_q;
  assign io.valid    = valid_q;
  assign io.busy     = (state_q == RUN);
  assign io.div_zero = dz_q;
endmodule
